gpio_cmd_decoder: RTL and testbench

Command decoder between the processor GPIO bus and the modem datapath.
- Detects a rising edge on the enable bit of i_gpo and decodes the 8-bit command.
- Drives registered control outputs: system reset, Tx/Rx enables, phase select, log run/read, log address.
- Multiplexes BER counters, log-memory data and the memory-full flag back onto o_gpi.
- Instantiated inside top, between the GPIO ports and the Tx/Rx/BER/logger blocks.

---
 rtl/gpio_cmd_decoder_pkg.sv | 40 ++++
 rtl/gpio_edge_det.sv | 39 +++
 rtl/gpio_cmd_decoder.sv | 184 ++++++++++++++++++
 tb/tb_gpio_cmd_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cmd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder_pkg
// Shared definitions for the GPIO command decoder:
//   - GPIO word field positions (command byte, enable bit)
//   - command codes issued by the processor
//   - decoder FSM state type
//   - is_ber_cmd(): true for the four BER counter snapshot commands
// -----------------------------------------------------------------------------
package gpio_cmd_decoder_pkg;

  // GPIO word layout: [31:24] command, [23] enable, [22:0] payload
  localparam int CMD_MSB = 31;
  localparam int CMD_LSB = 24;
  localparam int EN_BIT  = 23;

  localparam logic [7:0] CMD_RESET       = 8'd0;
  localparam logic [7:0] CMD_EN_TX       = 8'd1;
  localparam logic [7:0] CMD_EN_RX       = 8'd2;
  localparam logic [7:0] CMD_PH_SEL      = 8'd3;
  localparam logic [7:0] CMD_RUN_MEM     = 8'd4;
  localparam logic [7:0] CMD_READ_MEM    = 8'd5;
  localparam logic [7:0] CMD_ADDR_MEM    = 8'd6;
  localparam logic [7:0] CMD_BER_S_I     = 8'd7;
  localparam logic [7:0] CMD_BER_S_Q     = 8'd8;
  localparam logic [7:0] CMD_BER_E_I     = 8'd9;
  localparam logic [7:0] CMD_BER_E_Q     = 8'd10;
  localparam logic [7:0] CMD_BER_H       = 8'd11;
  localparam logic [7:0] CMD_IS_MEM_FULL = 8'd12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_CAP  = 2'd2
  } state_t;

  function automatic logic is_ber_cmd(input logic [7:0] cmd);
    return (cmd >= CMD_BER_S_I) && (cmd <= CMD_BER_E_Q);
  endfunction

endpackage

// File: rtl/gpio_edge_det.sv
// -----------------------------------------------------------------------------
// gpio_edge_det
// Registers the raw GPIO output word and produces a one-cycle pulse when the
// enable bit of the registered word goes from 0 to 1.
// Ports:
//   clk       in   clock
//   i_resetn  in   asynchronous active-low reset
//   i_gpo     in   raw GPIO word from the processor
//   gpo_q     out  registered GPIO word
//   cmd_edge  out  high for the cycle in which gpo_q[EN_BIT] first reads 1
// -----------------------------------------------------------------------------
module gpio_edge_det #(
  parameter int NB_GPIOS = 32,
  parameter int EN_BIT   = 23
) (
  input  logic                clk,
  input  logic                i_resetn,
  input  logic [NB_GPIOS-1:0] i_gpo,
  output logic [NB_GPIOS-1:0] gpo_q,
  output logic                cmd_edge
);

  logic en_prev_reg;

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      gpo_q       <= '0;
      en_prev_reg <= 1'b0;
    end else begin
      gpo_q       <= i_gpo;
      en_prev_reg <= gpo_q[EN_BIT];
    end
  end

  // A level-high enable produces a single pulse; the processor has to drop
  // the bit before the next command can be recognised.
  assign cmd_edge = gpo_q[EN_BIT] & ~en_prev_reg;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder
// Decodes processor commands written over the GPIO bus into registered
// datapath controls, and returns BER counters, log memory words and the
// memory-full flag on the read-back word.
// Ports:
//   clk100                  in   system clock
//   i_resetn                in   asynchronous active-low reset
//   i_gpo                   in   [31:24] command, [23] enable, [22:0] payload
//   o_gpi                   out  read-back word
//   o_rst                   out  datapath soft reset (active high)
//   o_enb_tx / o_enb_rx     out  Tx / Rx enables
//   o_phase_sel             out  filter phase select
//   o_run_log               out  one-cycle pulse starting memory logging
//   o_read_log              out  log memory in read mode
//   o_addr_log              out  log memory read address
//   i_mem_data              in   log memory data, one cycle after o_addr_log
//   i_mem_full              in   logger has filled the memory
//   i_ber_s_i .. i_ber_e_q  in   BER sample / error counters
// -----------------------------------------------------------------------------
module gpio_cmd_decoder
  import gpio_cmd_decoder_pkg::*;
#(
  parameter int NB_GPIOS        = 32,
  parameter int NB_CMD          = 8,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int NB_BER_CNT      = 64,
  parameter int NB_PHASE        = 2
) (
  input  logic                       clk100,
  input  logic                       i_resetn,
  input  logic [NB_GPIOS-1:0]        i_gpo,
  output logic [NB_GPIOS-1:0]        o_gpi,
  output logic                       o_rst,
  output logic                       o_enb_tx,
  output logic                       o_enb_rx,
  output logic [NB_PHASE-1:0]        o_phase_sel,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  input  logic [BRAM_DATA_WIDTH-1:0] i_mem_data,
  input  logic                       i_mem_full,
  input  logic [NB_BER_CNT-1:0]      i_ber_s_i,
  input  logic [NB_BER_CNT-1:0]      i_ber_s_q,
  input  logic [NB_BER_CNT-1:0]      i_ber_e_i,
  input  logic [NB_BER_CNT-1:0]      i_ber_e_q
);

  logic [NB_GPIOS-1:0] gpo_q;
  logic                cmd_edge;

  gpio_edge_det #(
    .NB_GPIOS (NB_GPIOS),
    .EN_BIT   (EN_BIT)
  ) u_edge_det (
    .clk      (clk100),
    .i_resetn (i_resetn),
    .i_gpo    (i_gpo),
    .gpo_q    (gpo_q),
    .cmd_edge (cmd_edge)
  );

  logic [NB_CMD-1:0] cmd;
  logic [EN_BIT-1:0] payload;

  assign cmd     = gpo_q[CMD_MSB:CMD_LSB];
  assign payload = gpo_q[EN_BIT-1:0];

  // Enable bit is consumed by the edge detector and the upper payload bits
  // carry no meaning for any command.
  logic unused_bits;
  assign unused_bits = ^{gpo_q[EN_BIT], payload[EN_BIT-1:BRAM_ADDR_WIDTH]};

  state_t                     state_reg, state_next;
  logic                       rst_reg, rst_next;
  logic                       enb_tx_reg, enb_tx_next;
  logic                       enb_rx_reg, enb_rx_next;
  logic [NB_PHASE-1:0]        phase_sel_reg, phase_sel_next;
  logic                       run_log_reg, run_log_next;
  logic                       read_log_reg, read_log_next;
  logic [BRAM_ADDR_WIDTH-1:0] addr_log_reg, addr_log_next;
  logic [NB_GPIOS-1:0]        gpi_reg, gpi_next;
  logic [NB_BER_CNT-1:0]      shadow_reg, shadow_next;
  logic [NB_BER_CNT-1:0]      ber_sel;

  always_comb begin
    case (cmd)
      CMD_BER_S_I: ber_sel = i_ber_s_i;
      CMD_BER_S_Q: ber_sel = i_ber_s_q;
      CMD_BER_E_I: ber_sel = i_ber_e_i;
      default:     ber_sel = i_ber_e_q;
    endcase
  end

  always_ff @(posedge clk100 or negedge i_resetn) begin
    if (!i_resetn) begin
      state_reg     <= ST_IDLE;
      rst_reg       <= 1'b1;
      enb_tx_reg    <= 1'b0;
      enb_rx_reg    <= 1'b0;
      phase_sel_reg <= '0;
      run_log_reg   <= 1'b0;
      read_log_reg  <= 1'b0;
      addr_log_reg  <= '0;
      gpi_reg       <= '0;
      shadow_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      rst_reg       <= rst_next;
      enb_tx_reg    <= enb_tx_next;
      enb_rx_reg    <= enb_rx_next;
      phase_sel_reg <= phase_sel_next;
      run_log_reg   <= run_log_next;
      read_log_reg  <= read_log_next;
      addr_log_reg  <= addr_log_next;
      gpi_reg       <= gpi_next;
      shadow_reg    <= shadow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rst_next       = rst_reg;
    enb_tx_next    = enb_tx_reg;
    enb_rx_next    = enb_rx_reg;
    phase_sel_next = phase_sel_reg;
    run_log_next   = 1'b0;
    read_log_next  = read_log_reg;
    addr_log_next  = addr_log_reg;
    gpi_next       = gpi_reg;
    shadow_next    = shadow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_edge) begin
          case (cmd)
            CMD_RESET:  rst_next       = payload[0];
            CMD_EN_TX:  enb_tx_next    = payload[0];
            CMD_EN_RX:  enb_rx_next    = payload[0];
            CMD_PH_SEL: phase_sel_next = payload[NB_PHASE-1:0];
            CMD_RUN_MEM: begin
              run_log_next  = 1'b1;
              read_log_next = 1'b0;
            end
            CMD_READ_MEM: begin
              read_log_next = 1'b1;
              addr_log_next = payload[BRAM_ADDR_WIDTH-1:0];
              state_next    = ST_MEM_WAIT;
            end
            CMD_ADDR_MEM: addr_log_next = payload[BRAM_ADDR_WIDTH-1:0];
            CMD_BER_H:    gpi_next = shadow_reg[NB_BER_CNT-1:NB_BER_CNT-NB_GPIOS];
            CMD_IS_MEM_FULL: gpi_next = {{(NB_GPIOS-1){1'b0}}, i_mem_full};
            default: begin
              // Whole counter is captured at once so a later BER_H returns
              // the high half matching the low half returned now.
              if (is_ber_cmd(cmd)) begin
                shadow_next = ber_sel;
                gpi_next    = ber_sel[NB_GPIOS-1:0];
              end
            end
          endcase
        end
      end
      // Address was presented last cycle; memory data lands next cycle.
      ST_MEM_WAIT: state_next = ST_MEM_CAP;
      ST_MEM_CAP: begin
        gpi_next   = {{(NB_GPIOS-BRAM_DATA_WIDTH){1'b0}}, i_mem_data};
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_gpi       = gpi_reg;
  assign o_rst       = rst_reg;
  assign o_enb_tx    = enb_tx_reg;
  assign o_enb_rx    = enb_rx_reg;
  assign o_phase_sel = phase_sel_reg;
  assign o_run_log   = run_log_reg;
  assign o_read_log  = read_log_reg;
  assign o_addr_log  = addr_log_reg;

endmodule

// File: tb/tb_gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_gpio_cmd_decoder
// Directed scenarios with literal expectations, then randomized command
// traffic. A transaction-level model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_gpio_cmd_decoder;

  logic        clk100 = 1'b0;
  logic        i_resetn;
  logic [31:0] i_gpo;
  logic [31:0] o_gpi;
  logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
  logic [1:0]  o_phase_sel;
  logic [14:0] o_addr_log;
  logic [15:0] i_mem_data;
  logic        i_mem_full;
  logic [63:0] i_ber_s_i, i_ber_s_q, i_ber_e_i, i_ber_e_q;

  gpio_cmd_decoder dut (
    .clk100      (clk100),
    .i_resetn    (i_resetn),
    .i_gpo       (i_gpo),
    .o_gpi       (o_gpi),
    .o_rst       (o_rst),
    .o_enb_tx    (o_enb_tx),
    .o_enb_rx    (o_enb_rx),
    .o_phase_sel (o_phase_sel),
    .o_run_log   (o_run_log),
    .o_read_log  (o_read_log),
    .o_addr_log  (o_addr_log),
    .i_mem_data  (i_mem_data),
    .i_mem_full  (i_mem_full),
    .i_ber_s_i   (i_ber_s_i),
    .i_ber_s_q   (i_ber_s_q),
    .i_ber_e_i   (i_ber_e_i),
    .i_ber_e_q   (i_ber_e_q)
  );

  always #5 clk100 = ~clk100;

  // Log memory: one-cycle read latency, content = address ^ 16'hA5A5
  always @(posedge clk100) i_mem_data <= {1'b0, o_addr_log} ^ 16'hA5A5;

  int checks = 0;
  int errors = 0;
  int run_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_rst, m_tx, m_rx, m_run, m_read, m_last_en;
  logic [1:0]  m_ph;
  logic [14:0] m_addr;
  logic [31:0] m_gpi, m_cap_val;
  logic [63:0] m_shadow;
  logic [7:0]  m_pcmd;
  logic [22:0] m_ppl;
  int          cyc = 0, m_pend_at, m_cap_at, m_busy_until;

  function automatic void model_reset();
    m_rst = 1'b1; m_tx = 1'b0; m_rx = 1'b0; m_ph = 2'd0; m_run = 1'b0;
    m_read = 1'b0; m_addr = 15'd0; m_gpi = 32'd0; m_shadow = 64'd0;
    m_last_en = 1'b0; m_pend_at = -1; m_cap_at = -1; m_busy_until = -1;
  endfunction

  function automatic void model_apply(input logic [7:0] c, input logic [22:0] pl);
    logic [63:0] cnt;
    case (c)
      8'd0: m_rst = pl[0];
      8'd1: m_tx  = pl[0];
      8'd2: m_rx  = pl[0];
      8'd3: m_ph  = pl[1:0];
      8'd4: begin m_run = 1'b1; m_read = 1'b0; end
      8'd5: begin
        m_read       = 1'b1;
        m_addr       = pl[14:0];
        m_cap_at     = cyc + 2;
        m_cap_val    = {16'd0, {1'b0, pl[14:0]} ^ 16'hA5A5};
        m_busy_until = cyc + 2;
      end
      8'd6: m_addr = pl[14:0];
      8'd7, 8'd8, 8'd9, 8'd10: begin
        cnt = (c == 8'd7) ? i_ber_s_i : (c == 8'd8) ? i_ber_s_q :
              (c == 8'd9) ? i_ber_e_i : i_ber_e_q;
        m_shadow = cnt;
        m_gpi    = cnt[31:0];
      end
      8'd11: m_gpi = m_shadow[63:32];
      8'd12: m_gpi = {31'd0, i_mem_full};
      default: ;
    endcase
  endfunction

  // A command whose enable is first seen at edge k takes effect at edge k+1,
  // unless a memory read is still occupying that edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk100);
      cyc++;
      if (!i_resetn) model_reset();
      else begin
        m_run = 1'b0;
        if (m_cap_at == cyc) m_gpi = m_cap_val;
        if (m_pend_at == cyc && cyc > m_busy_until) model_apply(m_pcmd, m_ppl);
        if (i_gpo[23] && !m_last_en) begin
          m_pend_at = cyc + 1;
          m_pcmd    = i_gpo[31:24];
          m_ppl     = i_gpo[22:0];
        end
        m_last_en = i_gpo[23];
      end
    end
  end

  // Cycle-by-cycle compare
  initial begin
    forever begin
      @(posedge clk100);
      #1;
      if (o_run_log === 1'b1) run_cnt++;
      chk("gpi",      64'(o_gpi),       64'(m_gpi));
      chk("rst",      64'(o_rst),       64'(m_rst));
      chk("enb_tx",   64'(o_enb_tx),    64'(m_tx));
      chk("enb_rx",   64'(o_enb_rx),    64'(m_rx));
      chk("phase",    64'(o_phase_sel), 64'(m_ph));
      chk("run_log",  64'(o_run_log),   64'(m_run));
      chk("read_log", 64'(o_read_log),  64'(m_read));
      chk("addr_log", 64'(o_addr_log),  64'(m_addr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] c, input logic [22:0] pl, input int hold, input int gap);
    @(negedge clk100);
    i_gpo = {c, 1'b1, pl};
    repeat (hold) @(negedge clk100);
    i_gpo[23] = 1'b0;
    repeat (gap) @(negedge clk100);
  endtask

  int run_before;

  initial begin
    i_resetn = 1'b0; i_gpo = 32'd0; i_mem_full = 1'b0;
    i_ber_s_i = 64'd0; i_ber_s_q = 64'd0; i_ber_e_i = 64'd0; i_ber_e_q = 64'd0;
    repeat (3) @(negedge clk100);
    chk("reset_rst", 64'(o_rst), 64'd1);
    chk("reset_gpi", 64'(o_gpi), 64'd0);
    chk("reset_ctl", 64'({o_enb_tx, o_enb_rx, o_phase_sel, o_run_log, o_read_log, o_addr_log}), 64'd0);
    i_resetn = 1'b1;
    repeat (2) @(negedge clk100);

    // 1: RESET latency
    i_gpo = {8'd0, 1'b1, 23'd0};
    @(negedge clk100);
    chk("rst_lat_edge1", 64'(o_rst), 64'd1);
    @(negedge clk100);
    chk("rst_lat_edge2", 64'(o_rst), 64'd0);
    i_gpo[23] = 1'b0;
    repeat (3) @(negedge clk100);
    send(8'd0, 23'd1, 1, 4); chk("rst_set", 64'(o_rst), 64'd1);
    send(8'd0, 23'd0, 1, 4); chk("rst_clr", 64'(o_rst), 64'd0);

    // 2: enables, phase, no retrigger
    send(8'd1, 23'd1, 1, 4); chk("enb_tx_on", 64'(o_enb_tx), 64'd1);
    send(8'd2, 23'd1, 1, 4); chk("enb_rx_on", 64'(o_enb_rx), 64'd1);
    for (int p = 0; p < 4; p++) begin
      send(8'd3, 23'(p), 1, 4);
      chk("phase_step", 64'(o_phase_sel), 64'(p));
    end
    @(negedge clk100);
    i_gpo = {8'd3, 1'b1, 23'd2};
    repeat (3) @(negedge clk100);
    i_gpo = {8'd3, 1'b1, 23'd1};
    repeat (7) @(negedge clk100);
    i_gpo[23] = 1'b0;
    repeat (4) @(negedge clk100);
    chk("no_retrigger", 64'(o_phase_sel), 64'd2);

    // 3: BER snapshot coherence
    i_ber_e_i = 64'h0000_0012_3456_789A;
    send(8'd9, 23'd0, 1, 4);  chk("ber_e_i_lo", 64'(o_gpi), 64'h3456789A);
    i_ber_e_i = 64'hFFFF_FFFF_0000_0000;
    send(8'd11, 23'd0, 1, 4); chk("ber_h", 64'(o_gpi), 64'h00000012);

    // 4: RUN_MEM pulse, memory full flag
    run_before = run_cnt;
    send(8'd4, 23'd0, 1, 4);
    chk("run_pulse_len", 64'(run_cnt - run_before), 64'd1);
    i_mem_full = 1'b0; send(8'd12, 23'd0, 1, 4); chk("mem_full0", 64'(o_gpi), 64'd0);
    i_mem_full = 1'b1; send(8'd12, 23'd0, 1, 4); chk("mem_full1", 64'(o_gpi), 64'd1);

    // 5: memory reads
    @(negedge clk100);
    i_gpo = {8'd5, 1'b1, 23'd10};
    repeat (2) @(negedge clk100);
    chk("rd_addr10", 64'(o_addr_log), 64'd10);
    chk("rd_mode",   64'(o_read_log), 64'd1);
    i_gpo[23] = 1'b0;
    repeat (2) @(negedge clk100);
    chk("rd_data10", 64'(o_gpi), 64'h0000A5AF);
    repeat (2) @(negedge clk100);
    send(8'd5, 23'h431C, 1, 4);
    chk("rd_addr431c", 64'(o_addr_log), 64'h431C);
    chk("rd_data431c", 64'(o_gpi), 64'h0000E6B9);

    // 6: reset while waiting for memory data
    @(negedge clk100);
    i_gpo = {8'd5, 1'b1, 23'd7};
    repeat (2) @(negedge clk100);
    i_resetn = 1'b0; i_gpo = 32'd0;
    #1;
    chk("midrd_gpi",  64'(o_gpi),      64'd0);
    chk("midrd_read", 64'(o_read_log), 64'd0);
    repeat (2) @(negedge clk100);
    i_resetn = 1'b1;
    repeat (2) @(negedge clk100);
    send(8'd12, 23'd0, 1, 4); chk("post_rst_idle", 64'(o_gpi), 64'd1);
    send(8'd11, 23'd0, 1, 4); chk("ber_h_no_snap", 64'(o_gpi), 64'd0);
    send(8'd12, 23'd0, 1, 4);
    send(8'd1, 23'd1, 1, 4);
    send(8'd200, 23'h7FFFFF, 1, 4);
    chk("ign_gpi", 64'(o_gpi),    64'd1);
    chk("ign_tx",  64'(o_enb_tx), 64'd1);
    chk("ign_rst", 64'(o_rst),    64'd1);

    // Randomized traffic, including commands landing on a busy read
    for (int n = 0; n < 400; n++) begin
      logic [7:0] c;
      int r;
      i_ber_s_i = {$urandom, $urandom}; i_ber_s_q = {$urandom, $urandom};
      i_ber_e_i = {$urandom, $urandom}; i_ber_e_q = {$urandom, $urandom};
      i_mem_full = 1'($urandom);
      r = $urandom_range(0, 15);
      c = (r <= 12) ? 8'(r) : 8'($urandom_range(13, 255));
      send(c, 23'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk100);
        i_resetn = 1'b0; i_gpo = 32'd0;
        @(negedge clk100);
        i_resetn = 1'b1;
      end
    end
    repeat (5) @(negedge clk100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
